stream_fifo: RTL and testbench
==============================

# stream_fifo

Parametrised, reset-clean successor to the terminal's byte FIFO. It buffers words between a producer that issues single-cycle write strobes and a consumer. The consumer side can run in the legacy one-word-per-two-cycles pulse mode or in a back-to-back valid/ready stream mode. It adds full/empty/level status, an almost-full threshold for upstream throttling, overflow protection with a sticky error flag, and a synchronous flush.

## Interface
- DATA_WIDTH, 8: word width in bits.
- FIFO_SIZE, 32: storage depth in words; power of two, ≥ 2. All FIFO_SIZE entries are usable.
- ALMOST_FULL, 24: almost_full asserts when level ≥ this value; range 1..FIFO_SIZE.
- OUTPUT_MODE, 0: 0 = pulse mode, 1 = stream mode.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of contents.
- in_data  in  DATA_WIDTH  write word.
- in_data_available  in  1  write strobe; one word per high cycle.
- receiver_ready  in  1  consumer ready.
- out_data_available  out  1  pulse mode: one-cycle data strobe; stream mode: valid.
- out_data  out  DATA_WIDTH  output word (registered).
- level  out  $clog2(FIFO_SIZE)+1  words held in storage; excludes the output register.
- empty  out  1  level == 0.
- full  out  1  level == FIFO_SIZE.
- almost_full  out  1  level ≥ ALMOST_FULL.
- overflow  out  1  sticky: a write was dropped.
- clear_overflow  in  1  clears overflow.

## Operation
- Priority each cycle: reset > flush > normal operation.
- Reset values:
  - write/read pointers and level = 0, so empty = 1, full = 0, almost_full = 0.
  - out_data_available = 0, out_data = 0, overflow = 0.
- Write:
  - Accepted iff in_data_available && !full, judged on pre-edge state.
  - An accepted word is stored at the write pointer, and the write pointer increments, wrapping modulo FIFO_SIZE.
  - A write while full is dropped: no storage or pointer change, and overflow is set. This holds even if a pop occurs the same cycle.
- Pop: the read pointer increments (wrapping) and level decrements. A word written in the same cycle is not poppable until the next cycle.
- level = level + write_accepted − pop, computed in the full width. Simultaneous accepted write and pop leaves level unchanged.
- Pulse mode (OUTPUT_MODE = 0):
  - If out_data_available = 1, drive it to 0 next cycle.
  - Else, if receiver_ready && !empty: load out_data from the read pointer, drive out_data_available = 1, and pop.
  - Otherwise out_data_available = 0.
  - Maximum rate is one word per 2 cycles.
- Stream mode (OUTPUT_MODE = 1):
  - A transfer occurs when out_data_available && receiver_ready.
  - If (!out_data_available || transfer) && !empty: load out_data from the read pointer, set out_data_available = 1, and pop.
  - Else if transfer: clear out_data_available.
  - While out_data_available && !receiver_ready, out_data and out_data_available hold stable.
  - Sustains one word per cycle.
- Flush:
  - Clears pointers and level, and forces out_data_available = 0.
  - out_data and overflow are unchanged.
  - A write in the flush cycle is discarded and does not set overflow.
- Overflow: set on a dropped write, cleared by clear_overflow. Set wins if both happen in the same cycle.
- empty, full and almost_full are decoded from the level register with no added latency.

## Timing
- Write to output, stream mode: word written at edge k (FIFO empty, output invalid) gives out_data_available = 1 with that word after edge k+1.
- Write to output, pulse mode: receiver_ready high from edge k+1 gives the strobe after edge k+1.
- Status outputs (level, empty, full, almost_full) reflect writes and pops one edge after the event.
- Capacity in stream mode is FIFO_SIZE words in storage plus 1 in the output register.
- Pointers wrap silently. The extra level bit distinguishes full from empty.
- reset or flush mid-transfer takes effect at that edge. No partial word is ever presented.

## Test plan
- Reset, then idle 5 cycles: all outputs at reset values, level = 0, empty = 1.
- Pulse mode, 8, 32: write 0x41, 0x42, 0x43 on consecutive cycles, then hold receiver_ready = 1. Required: strobes on alternate cycles carrying 0x41, 0x42, 0x43 in order, with out_data_available low between them.
- Stream mode: write 40 incrementing bytes 0x00..0x27 with receiver_ready = 0. Required:
  - almost_full rises when level reaches 24.
  - full rises at level 32.
  - Writes 0x21..0x27 are dropped and overflow = 1.
  - Releasing ready yields 0x00..0x20 back-to-back, one per cycle, with no gap.
- Stream mode backpressure: toggle receiver_ready every cycle while streaming 100 random words. Required: output matches input order exactly, and out_data is stable whenever valid && !ready.
- Simultaneous events:
  - Write and pop in the same cycle at level 10: level stays 10.
  - Write while full with a concurrent pop: write dropped, overflow set.
  - clear_overflow together with a dropped write: overflow stays 1.
- Flush at level 17 with a write in the same cycle: after the edge, level = 0, empty = 1, out_data_available = 0, overflow unchanged. The next write 0x55 is the first word output.

Source files
------------

// File: rtl/stream_fifo.sv
// Word FIFO between a strobe-driven producer and a consumer that runs either in
// two-cycle pulse mode or in back-to-back valid/ready stream mode.
module stream_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_SIZE   = 32,
  parameter int ALMOST_FULL = 24,
  parameter int OUTPUT_MODE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_data_available,
  input  logic                        receiver_ready,
  output logic                        out_data_available,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(FIFO_SIZE):0]  level,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        overflow,
  input  logic                        clear_overflow
);
  localparam int AW = $clog2(FIFO_SIZE);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_SIZE);
  localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_SIZE];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_accept;
  logic                  w_wr_drop;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_valid_next;
  logic [LW-1:0]         w_level_next;

  // Status decode straight off the level register; the extra level bit separates full from empty.
  assign w_empty      = (r_level == {LW{1'b0}});
  assign w_full       = (r_level == LVL_FULL);
  assign w_wr_accept  = in_data_available & ~w_full;
  assign w_wr_drop    = in_data_available & w_full;
  assign w_xfer       = r_valid & receiver_ready;
  assign w_level_next = r_level + {{AW{1'b0}}, w_wr_accept} - {{AW{1'b0}}, w_pop};

  assign out_data_available = r_valid;
  assign out_data           = r_out_data;
  assign level              = r_level;
  assign empty              = w_empty;
  assign full               = w_full;
  assign almost_full        = (r_level >= LVL_AF);
  assign overflow           = r_overflow;

  // Consumer-side pop decision; a word written this cycle is never visible to the pop.
  always_comb begin
    w_pop        = 1'b0;
    w_valid_next = r_valid;
    if (OUTPUT_MODE == 0) begin
      if (r_valid) begin
        w_valid_next = 1'b0;
      end else if (receiver_ready && !w_empty) begin
        w_pop        = 1'b1;
        w_valid_next = 1'b1;
      end else begin
        w_valid_next = 1'b0;
      end
    end else begin
      if ((!r_valid || w_xfer) && !w_empty) begin
        w_pop        = 1'b1;
        w_valid_next = 1'b1;
      end else if (w_xfer) begin
        w_valid_next = 1'b0;
      end else begin
        w_valid_next = r_valid;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_wr_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers, level, output register and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_valid    <= 1'b0;
      r_out_data <= {DATA_WIDTH{1'b0}};
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_level    <= {LW{1'b0}};
      r_valid    <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
        r_out_data <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_next;
      r_valid <= w_valid_next;
      // A dropped write outranks a clear in the same cycle.
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Runs a pulse-mode and a stream-mode stream_fifo side by side on shared stimulus,
// checking both against a queue-based model every cycle plus directed literal checks.
module tb_stream_fifo;
  typedef logic [7:0] byteq_t[$];

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] in_data;
  logic       in_av;
  logic       rdy;
  logic       clr;

  logic       p_v, p_emp, p_ful, p_af, p_ov;
  logic [7:0] p_d;
  logic [5:0] p_lvl;
  logic       s_v, s_emp, s_ful, s_af, s_ov;
  logic [7:0] s_d;
  logic [5:0] s_lvl;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic started = 1'b0;

  byteq_t     mq [2];
  logic       mv [2];
  logic [7:0] md [2];
  logic       mov [2];

  byteq_t pcap;
  int     pcyc[$];
  byteq_t scap;
  int     scyc[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_d;

  stream_fifo #(.DATA_WIDTH(8), .FIFO_SIZE(32), .ALMOST_FULL(24), .OUTPUT_MODE(0)) u_pulse (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
    .in_data_available(in_av), .receiver_ready(rdy),
    .out_data_available(p_v), .out_data(p_d), .level(p_lvl), .empty(p_emp),
    .full(p_ful), .almost_full(p_af), .overflow(p_ov), .clear_overflow(clr)
  );

  stream_fifo #(.DATA_WIDTH(8), .FIFO_SIZE(32), .ALMOST_FULL(24), .OUTPUT_MODE(1)) u_stream (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
    .in_data_available(in_av), .receiver_ready(rdy),
    .out_data_available(s_v), .out_data(s_d), .level(s_lvl), .empty(s_emp),
    .full(s_ful), .almost_full(s_af), .overflow(s_ov), .clear_overflow(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model update and output capture, using values as they stood before the edge.
  always @(posedge clk) begin
    int   sz;
    logic xfer;
    cyc++;
    if (started && p_v) begin
      pcap.push_back(p_d);
      pcyc.push_back(cyc);
    end
    if (started && s_v && rdy && !reset && !flush) begin
      scap.push_back(s_d);
      scyc.push_back(cyc);
    end
    hold_pend = started && s_v && !rdy && !reset && !flush;
    hold_d    = s_d;
    if (reset) started = 1'b1;
    for (int m = 0; m < 2; m++) begin
      sz = mq[m].size();
      if (reset) begin
        mq[m].delete();
        mv[m] = 1'b0; md[m] = 8'h00; mov[m] = 1'b0;
      end else if (flush) begin
        mq[m].delete();
        mv[m] = 1'b0;
      end else begin
        if (m == 1) begin
          xfer = mv[m] && rdy;
          if ((!mv[m] || xfer) && sz > 0) begin
            md[m] = mq[m].pop_front(); mv[m] = 1'b1;
          end else if (xfer) begin
            mv[m] = 1'b0;
          end
        end else begin
          if (mv[m]) mv[m] = 1'b0;
          else if (rdy && sz > 0) begin
            md[m] = mq[m].pop_front(); mv[m] = 1'b1;
          end
        end
        if (in_av && sz < 32) mq[m].push_back(in_data);
        if (in_av && sz == 32) mov[m] = 1'b1;
        else if (clr) mov[m] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    int n;
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        n = mq[m].size();
        chk($sformatf("valid[%0d]", m), m == 0 ? p_v : s_v, mv[m]);
        chk($sformatf("data[%0d]", m), m == 0 ? p_d : s_d, md[m]);
        chk($sformatf("level[%0d]", m), m == 0 ? p_lvl : s_lvl, n);
        chk($sformatf("empty[%0d]", m), m == 0 ? p_emp : s_emp, n == 0);
        chk($sformatf("full[%0d]", m), m == 0 ? p_ful : s_ful, n == 32);
        chk($sformatf("almost_full[%0d]", m), m == 0 ? p_af : s_af, n >= 24);
        chk($sformatf("overflow[%0d]", m), m == 0 ? p_ov : s_ov, mov[m]);
      end
      if (hold_pend) begin
        chk("hold_valid", s_v, 1'b1);
        chk("hold_data", s_d, hold_d);
      end
    end
  end

  task automatic drive(input logic w, input logic [7:0] dat, input logic r,
                       input logic f, input logic c, input logic rs);
    in_av = w; in_data = dat; rdy = r; flush = f; clr = c; reset = rs;
    @(negedge clk);
    in_av = 1'b0; flush = 1'b0; clr = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int   exp_l;
    int   gaps;
    int   written;
    logic tog;
    byteq_t expq;

    reset = 1'b1; flush = 1'b0; in_data = 8'h00; in_av = 1'b0; rdy = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state held over idle cycles.
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_level", s_lvl, 32'd0);
    chk("rst_empty", s_emp, 32'd1);
    chk("rst_valid", s_v, 32'd0);
    chk("rst_data", s_d, 32'd0);
    chk("rst_pulse_valid", p_v, 32'd0);
    chk("rst_overflow", s_ov, 32'd0);

    // Pulse mode: three words come out on alternate cycles.
    pcap.delete(); pcyc.delete();
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pulse_count", pcap.size(), 32'd3);
    if (pcap.size() == 3) begin
      chk("pulse_w0", pcap[0], 32'h41);
      chk("pulse_w1", pcap[1], 32'h42);
      chk("pulse_w2", pcap[2], 32'h43);
      chk("pulse_gap0", pcyc[1] - pcyc[0], 32'd2);
      chk("pulse_gap1", pcyc[2] - pcyc[1], 32'd2);
    end

    // Stream mode fill with ready low: one word parks in the output register.
    scap.delete(); scyc.delete();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      exp_l = (i == 0) ? 1 : ((i > 32) ? 32 : i);
      chk("fill_level", s_lvl, exp_l);
      chk("fill_af", s_af, exp_l >= 24);
      chk("fill_full", s_ful, exp_l == 32);
    end
    chk("fill_overflow", s_ov, 32'd1);
    for (int i = 0; i < 70; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drain_count", scap.size(), 32'd33);
    gaps = 0;
    for (int i = 0; i < scap.size(); i++) begin
      if (i < 33) chk("drain_word", scap[i], i);
      if (i > 0 && scyc[i] - scyc[i-1] != 1) gaps++;
    end
    chk("drain_gaps", gaps, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_ovf", s_ov, 32'd0);

    // Backpressure: ready toggles every cycle while 100 random words stream through.
    scap.delete(); scyc.delete(); expq.delete();
    written = 0; tog = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic w;
      logic [7:0] dv;
      w  = (written < 100) && ($urandom_range(0, 9) < 4);
      dv = 8'($urandom);
      if (w) begin expq.push_back(dv); written++; end
      drive(w, dv, tog, 1'b0, 1'b0, 1'b0);
      tog = ~tog;
    end
    chk("bp_count", scap.size(), expq.size());
    gaps = 0;
    for (int i = 0; i < scap.size() && i < expq.size(); i++)
      if (scap[i] !== expq[i]) gaps++;
    chk("bp_order", gaps, 32'd0);

    // Simultaneous write and pop at level 10.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lvl10_pre", s_lvl, 32'd10);
    drive(1'b1, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lvl10_post", s_lvl, 32'd10);
    for (int i = 0; i < 22; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_pre", s_ful, 32'd1);
    chk("ovf_pre", s_ov, 32'd0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("drop_pop_ovf", s_ov, 32'd1);
    chk("drop_pop_level", s_lvl, 32'd31);
    drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refull", s_ful, 32'd1);
    drive(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("set_beats_clear", s_ov, 32'd1);
    chk("set_beats_clear_lvl", s_lvl, 32'd32);

    // Flush at level 17 with a write in the same cycle.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lvl17", s_lvl, 32'd17);
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_level", s_lvl, 32'd0);
    chk("flush_empty", s_emp, 32'd1);
    chk("flush_valid", s_v, 32'd0);
    chk("flush_ovf", s_ov, 32'd1);
    pcap.delete(); scap.delete();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w2o_edge_k", s_v, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w2o_valid", s_v, 32'd1);
    chk("w2o_data", s_d, 32'h55);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_first_stream", scap.size() > 0 ? scap[0] : 8'hxx, 32'h55);
    chk("flush_first_pulse", pcap.size() > 0 ? pcap[0] : 8'hxx, 32'h55);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("final_clear", s_ov, 32'd0);

    // Fully random traffic including rare reset, flush and overflow clears.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 199) < 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
